// File: rtl/cla_add_sub4_pkg.sv
// cla_pkg: shared width, word type and group generate/propagate helper for the 4-bit CLA
// Exports: CLA_W, cla_word_t, cla_gp(g,p) -> {G,P}
package cla_pkg;
    localparam int CLA_W = 4;
    typedef logic [CLA_W-1:0] cla_word_t;
    function automatic logic [1:0] cla_gp(input cla_word_t g, input cla_word_t p);
        return {g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0], &p};
    endfunction
endpackage

// File: rtl/cla_add_sub4_if.sv
// cla_add_sub4_if: operand/result bundle of the CLA adder/subtractor
// master drives sub, cin, x, y, sticky_clr; slave drives out, cout, v, g, p, v_sticky
interface cla_add_sub4_if;
    import cla_pkg::*;
    logic      sub;
    logic      cin;
    cla_word_t x;
    cla_word_t y;
    logic      sticky_clr;
    cla_word_t out;
    logic      cout;
    logic      v;
    logic      g;
    logic      p;
    logic      v_sticky;
    modport master (output sub, cin, x, y, sticky_clr, input out, cout, v, g, p, v_sticky);
    modport slave (input sub, cin, x, y, sticky_clr, output out, cout, v, g, p, v_sticky);
endinterface

// File: rtl/cla_add_sub4_carry_unit4.sv
// cla_carry_unit4: 4-bit lookahead carry network with group generate/propagate
// Ports: i_g/i_p bit generate/propagate, i_c0 carry-in, o_c carries c4..c1, o_grp_g/o_grp_p group terms
module cla_carry_unit4
    import cla_pkg::*;
(
    input  cla_word_t  i_g,
    input  cla_word_t  i_p,
    input  logic       i_c0,
    output logic [4:1] o_c,
    output logic       o_grp_g,
    output logic       o_grp_p
);
    assign o_c[1] = i_g[0] | i_p[0] & i_c0;
    assign o_c[2] = i_g[1] | i_p[1] & i_g[0] | i_p[1] & i_p[0] & i_c0;
    assign o_c[3] = i_g[2] | i_p[2] & i_g[1] | i_p[2] & i_p[1] & i_g[0]
                  | i_p[2] & i_p[1] & i_p[0] & i_c0;
    assign o_c[4] = i_g[3] | i_p[3] & i_g[2] | i_p[3] & i_p[2] & i_g[1]
                  | i_p[3] & i_p[2] & i_p[1] & i_g[0] | i_p[3] & i_p[2] & i_p[1] & i_p[0] & i_c0;
    assign {o_grp_g, o_grp_p} = cla_gp(i_g, i_p);
endmodule

// File: rtl/cla_add_sub4.sv
// cla_add_sub4: 4-bit carry-lookahead adder/subtractor with overflow, group G/P and sticky overflow
// Ports: clk, rst (async, active-high), bus (slave: sub, cin, x, y, sticky_clr -> out, cout, v, g, p, v_sticky)
// Macro CLA_ADD_SUB_OUTREG_EN registers out/cout/v/g/p for one cycle of latency
module cla_add_sub4
    import cla_pkg::*;
(
    input logic           clk,
    input logic           rst,
    cla_add_sub4_if.slave bus
);
    cla_word_t  w_yy;
    cla_word_t  w_g;
    cla_word_t  w_p;
    cla_word_t  w_sum;
    logic [4:1] w_c;
    logic       w_c0;
    logic       w_cout;
    logic       w_v;
    logic       w_grp_g;
    logic       w_grp_p;
    logic       r_v_sticky;
    // subtraction is x + ~y + ~cin, so borrow-in and borrow-out are inverted carries
    assign w_yy = bus.y ^ {CLA_W{bus.sub}};
    assign w_g = bus.x & w_yy;
    assign w_p = bus.x ^ w_yy;
    assign w_c0 = bus.cin ^ bus.sub;
    cla_carry_unit4 u_carry (
        .i_g     (w_g),
        .i_p     (w_p),
        .i_c0    (w_c0),
        .o_c     (w_c),
        .o_grp_g (w_grp_g),
        .o_grp_p (w_grp_p)
    );
    assign w_sum = w_p ^ {w_c[3:1], w_c0};
    assign w_cout = w_c[4] ^ bus.sub;
    assign w_v = w_c[4] ^ w_c[3];
    always_ff @(posedge clk or posedge rst)
        if (rst) r_v_sticky <= 1'b0;
        else r_v_sticky <= bus.sticky_clr ? 1'b0 : r_v_sticky | w_v;
    assign bus.v_sticky = r_v_sticky;
`ifdef CLA_ADD_SUB_OUTREG_EN
    cla_word_t r_out;
    logic      r_cout;
    logic      r_v;
    logic      r_g;
    logic      r_p;
    always_ff @(posedge clk or posedge rst)
        if (rst) {r_out, r_cout, r_v, r_g, r_p} <= '0;
        else {r_out, r_cout, r_v, r_g, r_p} <= {w_sum, w_cout, w_v, w_grp_g, w_grp_p};
    assign bus.out = r_out;
    assign bus.cout = r_cout;
    assign bus.v = r_v;
    assign bus.g = r_g;
    assign bus.p = r_p;
`else
    assign bus.out = w_sum;
    assign bus.cout = w_cout;
    assign bus.v = w_v;
    assign bus.g = w_grp_g;
    assign bus.p = w_grp_p;
`endif
endmodule

// File: tb/tb_cla_add_sub4.sv
// tb_cla_add_sub4: self-checking bench for cla_add_sub4 (default combinational build)
module tb_cla_add_sub4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    cla_add_sub4_if bus ();
    cla_add_sub4 dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic exp_sticky = 1'b0;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic model(input logic s, input logic ci, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] o, output logic co, output logic ov,
                         output logic gg, output logic pp);
        int r;
        int sr;
        logic [3:0] bb;
        r = s ? int'(a) - int'(b) - int'(ci) : int'(a) + int'(b) + int'(ci);
        sr = s ? int'($signed(a)) - int'($signed(b)) - int'(ci)
               : int'($signed(a)) + int'($signed(b)) + int'(ci);
        o = r[3:0];
        co = s ? (r < 0) : (r > 15);
        ov = (sr > 7) || (sr < -8);
        bb = s ? ~b : b;
        gg = (int'(a) + int'(bb)) > 15;
        pp = (a ^ bb) == 4'hf;
    endtask
    task automatic drive(input logic s, input logic ci, input logic [3:0] a, input logic [3:0] b,
                         input logic clr);
        bus.sub = s;
        bus.cin = ci;
        bus.x = a;
        bus.y = b;
        bus.sticky_clr = clr;
    endtask
    task automatic check_comb(input string tag);
        logic [3:0] o;
        logic co, ov, gg, pp;
        model(bus.sub, bus.cin, bus.x, bus.y, o, co, ov, gg, pp);
        chk({tag, ".out"}, {4'h0, bus.out}, {4'h0, o});
        chk({tag, ".cout"}, {7'h0, bus.cout}, {7'h0, co});
        chk({tag, ".v"}, {7'h0, bus.v}, {7'h0, ov});
        chk({tag, ".g"}, {7'h0, bus.g}, {7'h0, gg});
        chk({tag, ".p"}, {7'h0, bus.p}, {7'h0, pp});
    endtask
    task automatic clock_and_check(input string tag);
        logic [3:0] o;
        logic co, ov, gg, pp;
        model(bus.sub, bus.cin, bus.x, bus.y, o, co, ov, gg, pp);
        @(posedge clk);
        exp_sticky = bus.sticky_clr ? 1'b0 : (exp_sticky | ov);
        #1;
        chk({tag, ".v_sticky"}, {7'h0, bus.v_sticky}, {7'h0, exp_sticky});
    endtask
    initial begin
        drive(1'b0, 1'b0, 4'd7, 4'd1, 1'b0);
        #1;
        chk("reset.v_sticky", {7'h0, bus.v_sticky}, 8'h0);
        check_comb("reset_comb");
        @(posedge clk);
        #1;
        chk("reset_hold.v_sticky", {7'h0, bus.v_sticky}, 8'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'b0111, 4'b0001, 1'b0);
        #1;
        chk("add7p1.out", {4'h0, bus.out}, 8'b1000);
        chk("add7p1.cout", {7'h0, bus.cout}, 8'h0);
        chk("add7p1.v", {7'h0, bus.v}, 8'h1);
        clock_and_check("stk_set");
        chk("stk_set_const", {7'h0, bus.v_sticky}, 8'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd1, 4'd1, 1'b0);
        clock_and_check("stk_hold");
        chk("stk_hold_const", {7'h0, bus.v_sticky}, 8'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd7, 4'd1, 1'b1);
        clock_and_check("stk_clr_pri");
        chk("stk_clr_const", {7'h0, bus.v_sticky}, 8'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd7, 4'd1, 1'b0);
        clock_and_check("stk_reset");
        @(negedge clk);
        #2 rst = 1'b1;
        exp_sticky = 1'b0;
        #1;
        chk("rst_pulse.v_sticky", {7'h0, bus.v_sticky}, 8'h0);
        @(posedge clk);
        #1;
        chk("rst_held.v_sticky", {7'h0, bus.v_sticky}, 8'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);
        bus.cin = 1'b0;
        #1;
        chk("add15p1.out", {4'h0, bus.out}, 8'h0);
        chk("add15p1.cout", {7'h0, bus.cout}, 8'h1);
        chk("add15p1.v", {7'h0, bus.v}, 8'h0);
        drive(1'b1, 1'b0, 4'b0011, 4'b0101, 1'b0);
        #1;
        chk("sub3m5.out", {4'h0, bus.out}, 8'b1110);
        chk("sub3m5.cout", {7'h0, bus.cout}, 8'h1);
        chk("sub3m5.v", {7'h0, bus.v}, 8'h0);
        drive(1'b1, 1'b0, 4'b1000, 4'b0001, 1'b0);
        #1;
        chk("sub8m1.out", {4'h0, bus.out}, 8'b0111);
        chk("sub8m1.cout", {7'h0, bus.cout}, 8'h0);
        chk("sub8m1.v", {7'h0, bus.v}, 8'h1);
        for (int ci = 0; ci < 2; ci++) begin
            drive(1'b0, ci[0], 4'b1111, 4'b0000, 1'b0);
            #1;
            chk("gp_f0.g", {7'h0, bus.g}, 8'h0);
            chk("gp_f0.p", {7'h0, bus.p}, 8'h1);
            drive(1'b0, ci[0], 4'b1000, 4'b1000, 1'b0);
            #1;
            chk("gp_88.g", {7'h0, bus.g}, 8'h1);
            chk("gp_88.p", {7'h0, bus.p}, 8'h0);
        end
        drive(1'b0, 1'b0, 4'bx000, 4'd1, 1'b0);
        #1;
        chk("xprop.out3", {7'h0, bus.out[3]}, 8'b0000000x);
        for (int i = 0; i < 1024; i++) begin
            drive(i[9], i[8], i[7:4], i[3:0], 1'b0);
            #1;
            check_comb("exh");
        end
        exp_sticky = bus.v_sticky;
        chk("exh_sticky_known", {7'h0, bus.v_sticky === 1'bx}, 8'h0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
            #1;
            check_comb("rnd");
            clock_and_check("rnd");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
